// File: rtl/tern_alu_sar_ctrl_if.sv
// ============================================================================
// tern_alu_sar_ctrl_if : start/op, comparator, DAC, ALU handshake and status
// Rev 1.0
// ============================================================================
`default_nettype none

interface tern_alu_sar_ctrl_if #(
  parameter int NBITS = 6
);
  logic             start;
  logic [1:0]       op;
  logic             cmp_in;
  logic             adc_ch;
  logic             sample;
  logic [NBITS-1:0] dac_code;
  logic             alu_req;
  logic [1:0]       alu_op;
  logic [NBITS-1:0] alu_a;
  logic [NBITS-1:0] alu_b;
  logic             alu_ack;
  logic [NBITS-1:0] alu_result;
  logic             busy;
  logic             done;
  logic             err;

  // master = surrounding system (analog front end, ALU, requester)
  modport master (
    output start, op, cmp_in, alu_ack, alu_result,
    input  adc_ch, sample, dac_code, alu_req, alu_op, alu_a, alu_b, busy, done, err
  );

  // slave = the sequencer
  modport slave (
    input  start, op, cmp_in, alu_ack, alu_result,
    output adc_ch, sample, dac_code, alu_req, alu_op, alu_a, alu_b, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/tern_alu_sar_ctrl.sv
// ============================================================================
// tern_alu_sar_ctrl : two SAR conversions on one DAC, then ALU req/ack, result parked on DAC
// Rev 1.0
// ============================================================================
`default_nettype none

module tern_alu_sar_ctrl #(
  parameter int NBITS       = 6,
  parameter int SAMPLE      = 4,
  parameter int SETTLE      = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  tern_alu_sar_ctrl_if.slave  bus
);

  localparam int CNT_MAX0 = (SAMPLE > SETTLE) ? SAMPLE : SETTLE;
  localparam int CNT_MAX  = (CNT_MAX0 > ACK_TIMEOUT) ? CNT_MAX0 : ACK_TIMEOUT;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int IW       = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAMPLE  = 3'd1,
    S_CONVERT = 3'd2,
    S_ALU     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [NBITS-1:0] acc, acc_nxt;
  logic [NBITS-1:0] dac, dac_nxt;
  logic [NBITS-1:0] a_reg, a_nxt;
  logic [NBITS-1:0] b_reg, b_nxt;
  logic [1:0]       op_reg, op_nxt;
  logic             ch, ch_nxt;
  logic             err_reg, err_nxt;
  logic [NBITS-1:0] acc_upd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      acc     <= '0;
      dac     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= '0;
      ch      <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      acc     <= acc_nxt;
      dac     <= dac_nxt;
      a_reg   <= a_nxt;
      b_reg   <= b_nxt;
      op_reg  <= op_nxt;
      ch      <= ch_nxt;
      err_reg <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    acc_nxt   = acc;
    dac_nxt   = dac;
    a_nxt     = a_reg;
    b_nxt     = b_reg;
    op_nxt    = op_reg;
    ch_nxt    = ch;
    err_nxt   = err_reg;
    // Trial bit is only ever set in dac, never in acc, so OR-ing is enough
    acc_upd   = bus.cmp_in ? (acc | (ONE << idx)) : acc;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_SAMPLE;
          op_nxt    = bus.op;
          ch_nxt    = 1'b0;
          err_nxt   = 1'b0;
          cnt_nxt   = '0;
          acc_nxt   = '0;
          dac_nxt   = '0;
        end
      end

      S_SAMPLE: begin
        if (cnt == CW'(SAMPLE - 1)) begin
          state_nxt = S_CONVERT;
          cnt_nxt   = '0;
          idx_nxt   = IW'(NBITS - 1);
          dac_nxt   = acc | (ONE << IW'(NBITS - 1));
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_CONVERT: begin
        if (cnt == CW'(SETTLE - 1)) begin
          cnt_nxt = '0;
          acc_nxt = acc_upd;
          if (idx == '0) begin
            if (!ch) begin
              a_nxt     = acc_upd;
              ch_nxt    = 1'b1;
              acc_nxt   = '0;
              dac_nxt   = '0;
              state_nxt = S_SAMPLE;
            end else begin
              b_nxt     = acc_upd;
              dac_nxt   = acc_upd;
              state_nxt = S_ALU;
            end
          end else begin
            idx_nxt = idx - IW'(1);
            dac_nxt = acc_upd | (ONE << (idx - IW'(1)));
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_ALU: begin
        if (bus.alu_ack) begin
          dac_nxt   = bus.alu_result;
          state_nxt = S_DONE;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          dac_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset removes them at once
  assign bus.sample   = (state == S_SAMPLE);
  assign bus.alu_req  = (state == S_ALU);
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.adc_ch   = ch;
  assign bus.dac_code = dac;
  assign bus.alu_a    = a_reg;
  assign bus.alu_b    = b_reg;
  assign bus.alu_op   = op_reg;
  assign bus.err      = err_reg;

endmodule

`default_nettype wire

// File: tb/tb_tern_alu_sar_ctrl.sv
// ============================================================================
// tb_tern_alu_sar_ctrl : table-driven sequences with a scoreboard of expected results
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tern_alu_sar_ctrl;
  localparam int NBITS = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tern_alu_sar_ctrl_if #(.NBITS(NBITS)) bus();

  tern_alu_sar_ctrl #(
    .NBITS(NBITS), .SAMPLE(4), .SETTLE(3), .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vin_a, vin_b, ack_delay, wcnt;
  bit hold_start;
  int checks = 0;
  int errors = 0;

  function automatic logic [5:0] alu_model(input logic [5:0] a, input logic [5:0] b,
                                           input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a ^ b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  assign bus.cmp_in     = ((bus.adc_ch ? vin_b : vin_a) >= int'(bus.dac_code));
  assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_ack    = bus.alu_req && (wcnt >= ack_delay);

  always @(posedge clk or posedge rst)
    if (rst || !bus.alu_req) wcnt <= 0;
    else                     wcnt <= wcnt + 1;

  typedef struct {
    int vin_a; int vin_b; int op; int delay; int exp_dac; int exp_err; int exp_done;
  } vec_t;

  typedef struct { int a; int b; int op; int dac; int err; int done_cyc; } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Trial code seen m cycles into a conversion of an input that resolves to v
  function automatic int trial(input int v, input int m);
    int i;
    i = NBITS - 1 - m / 3;
    return (v & ((63 << (i + 1)) & 63)) | (1 << i);
  endfunction

  task automatic expect_seq(input int va, input int vb, input int op, input int dly,
                            input int edac, input int eerr, input int edone);
    exp_t e;
    vin_a = va; vin_b = vb; ack_delay = dly; bus.op = 2'(op);
    e.a = va; e.b = vb; e.op = op; e.dac = edac; e.err = eerr; e.done_cyc = edone;
    sb.push_back(e);
  endtask

  task automatic launch(input int va, input int vb, input int op, input int dly,
                        input int edac, input int eerr, input int edone);
    expect_seq(va, vb, op, dly, edac, eerr, edone);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) bus.start = 1'b0;
  endtask

  // Called #1 after the edge that accepted start (cycle 0)
  task automatic observe(input int repulse_at, input int rst_at);
    exp_t e;
    bit seen;
    seen = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb[0];
    for (int n = 0; n < 200 && !seen; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (n == repulse_at) bus.start = 1'b1;
      else if (n == repulse_at + 1 && !hold_start) bus.start = 1'b0;
      if (bus.done) begin
        e = sb.pop_front();
        chk("done_cycle", n, e.done_cyc);
        chk("alu_a", int'(bus.alu_a), e.a);
        chk("alu_b", int'(bus.alu_b), e.b);
        chk("dac_result", int'(bus.dac_code), e.dac);
        chk("err", int'(bus.err), e.err);
        chk("req_dropped", int'(bus.alu_req), 0);
        seen = 1'b1;
      end else begin
        chk("busy", int'(bus.busy), 1);
        chk("err_clear", int'(bus.err), 0);
        if (n < 4 || (n >= 22 && n < 26)) begin
          chk("sample", int'(bus.sample), 1);
          chk("dac_in_sample", int'(bus.dac_code), 0);
          chk("adc_ch", int'(bus.adc_ch), (n >= 22) ? 1 : 0);
        end else if (n < 22) begin
          chk("trial_a", int'(bus.dac_code), trial(e.a, n - 4));
          chk("adc_ch_a", int'(bus.adc_ch), 0);
        end else if (n < 44) begin
          chk("trial_b", int'(bus.dac_code), trial(e.b, n - 26));
          chk("adc_ch_b", int'(bus.adc_ch), 1);
        end else begin
          chk("alu_req", int'(bus.alu_req), 1);
          chk("alu_a_stable", int'(bus.alu_a), e.a);
          chk("alu_b_stable", int'(bus.alu_b), e.b);
          chk("alu_op_stable", int'(bus.alu_op), e.op);
        end
      end
      if (n == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_sample", int'(bus.sample), 0);
        chk("rst_req", int'(bus.alu_req), 0);
        chk("rst_dac", int'(bus.dac_code), 0);
        chk("rst_alu_a", int'(bus.alu_a), 0);
        chk("rst_adc_ch", int'(bus.adc_ch), 0);
        chk("rst_done", int'(bus.done), 0);
        void'(sb.pop_front());
        repeat (3) begin
          @(posedge clk); #1;
          chk("no_done_in_rst", int'(bus.done), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic idle_gap(input int eerr);
    repeat (2) begin
      @(posedge clk); #1;
      chk("single_done", int'(bus.done), 0);
      chk("idle_busy", int'(bus.busy), 0);
      chk("err_sticky", int'(bus.err), eerr);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'd0;
    vin_a = 0; vin_b = 0; ack_delay = 0; hold_start = 1'b0;

    //           vin_a vin_b op delay dac err done
    vecs[0] = '{45,   18,   0, 0,    63,  0,  45};
    vecs[1] = '{0,    63,   0, 0,    63,  0,  45};
    vecs[2] = '{30,   40,   1, 0,    54,  0,  45};
    vecs[3] = '{10,   20,   0, 255,  0,   1,  60};
    vecs[4] = '{33,   7,    2, 5,    1,   0,  50};
    vecs[5] = '{63,   63,   3, 0,    63,  0,  45};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_sample", int'(bus.sample), 0);
    chk("reset_req", int'(bus.alu_req), 0);
    chk("reset_dac", int'(bus.dac_code), 0);
    chk("reset_alu_a", int'(bus.alu_a), 0);
    chk("reset_alu_b", int'(bus.alu_b), 0);
    chk("reset_err", int'(bus.err), 0);
    chk("reset_adc_ch", int'(bus.adc_ch), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      launch(vecs[i].vin_a, vecs[i].vin_b, vecs[i].op, vecs[i].delay,
             vecs[i].exp_dac, vecs[i].exp_err, vecs[i].exp_done);
      observe(-1, -1);
      idle_gap(vecs[i].exp_err);
    end

    // start re-pulsed mid-conversion is ignored
    launch(20, 25, 0, 0, 45, 0, 45);
    observe(10, -1);
    idle_gap(0);

    // start held through DONE: next sequence begins on the first IDLE edge
    hold_start = 1'b1;
    launch(12, 3, 0, 0, 15, 0, 45);
    observe(-1, -1);
    @(posedge clk); #1;
    chk("held_idle_busy", int'(bus.busy), 0);
    chk("held_single_done", int'(bus.done), 0);
    expect_seq(12, 3, 0, 0, 15, 0, 45);
    @(posedge clk); #1;
    hold_start = 1'b0;
    bus.start  = 1'b0;
    observe(-1, -1);
    idle_gap(0);

    // reset mid-conversion on ch1, then a clean restart
    launch(50, 37, 0, 0, 23, 0, 45);
    observe(-1, 30);
    launch(50, 37, 0, 0, 23, 0, 45);
    observe(-1, -1);
    idle_gap(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
